mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage between the EX stage and the WB stage of the in-order LoongArch core.
//  Collects the data-SRAM response for loads issued by EX, then sign- or zero-extends the load data.
//  Forwards rf write, exception and TLB bundles to WB, and drives ID bypass/stall information.
//  Drops and drains in-flight loads on WB flush.
// PARAMETERS
//  MAX_OUTSTANDING  1   data-SRAM requests EX may have in flight; sizes the cancel counter (fixed at 1 in this core)
// PORTS
//  clk               in   1   core clock, rising edge
//  reset             in   1   asynchronous, active-high reset
//  es_to_ms_valid    in   1   EX holds a valid instruction for MEM
//  ms_allowin        out  1   MEM accepts from EX this cycle
//  es_pc             in   32  instruction PC
//  es_result         in   32  ALU result / memory vaddr
//  es_rf_waddr       in   5   destination register
//  es_rf_we          in   1   writes rf
//  es_mem_req        in   1   EX issued a data-SRAM request (load or store) that was addr_ok'ed
//  es_ld_op          in   5   one-hot {ld.w, ld.h, ld.hu, ld.b, ld.bu}; 0 = not a load
//  es_csr_re         in   1   CSR read instruction
//  es_ex_zip         in   86  {csr_we,wmask,wvalue,csr_num,ertn,has_int,adef,sys,brk,ine,ale}
//  es2ms_tlb_zip     in   10  {refetch,tlbsrch,tlbrd,tlbwr,tlbfill,srch_found,srch_idx[3:0]}
//  data_sram_data_ok in   1   response for oldest outstanding request
//  data_sram_rdata   in   32  read data, valid with data_ok
//  ws_allowin        in   1   WB accepts
//  ms_to_ws_valid    out  1   MEM holds a finished instruction for WB
//  ms_pc             out  32  registered PC
//  ms_result         out  32  registered es_result (bad vaddr to WB)
//  ms_rf_wdata       out  32  load-extended data or ALU result
//  ms_rf_waddr       out  5   destination register
//  ms_rf_we          out  1   rf write enable
//  ms_csr_re         out  1   registered es_csr_re
//  ms_ex_zip         out  86  registered es_ex_zip
//  ms2ws_tlb_zip     out  10  registered es2ms_tlb_zip
//  ms_fwd_we         out  1   bypass valid to ID: ms_valid & ms_rf_we & ~ms_has_ex
//  ms_fwd_blk        out  1   ID must stall on match: pending load or csr_re in MEM
//  ms_ex_flag        out  1   MEM holds exception/ertn/refetch; EX suppresses new SRAM requests
//  wb_ex             in   1   WB exception flush
//  ertn_flush        in   1   WB ertn flush
//  wb_refetch_flush  in   1   WB refetch flush
// BEHAVIOUR
//  Reset: all registers 0; outputs derived from them read 0, ms_allowin=1.
//  flush = wb_ex|ertn_flush|wb_refetch_flush. On flush, ms_valid<=0 next cycle (priority over accept).
//  ms_ready_go = ~ms_mem_req_r | data_ok_seen | data_sram_data_ok (with cancel_cnt==0).
//  Held instructions with an exception in ms_ex_zip never wait for data_ok.
//  ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin). ms_to_ws_valid = ms_valid & ms_ready_go & ~flush.
//  Accept (es_to_ms_valid & ms_allowin): latch all es_* fields; clear data_ok_seen.
//  Zero-latency when data_ok arrives in the cycle after accept; otherwise hold until data_ok.
//  data_ok while ws_allowin=0: capture rdata into rdata_buf, set data_ok_seen; output from buffer.
//  Load extension: byte/half select by ms_result[1:0]; ld.b/ld.h sign-extend, .bu/.hu zero-extend.
//  Misaligned ld.h/ld.w never reach here without ale set; no SRAM data is used then.
//  Cancel: flush while (a) MEM holds an un-answered req or (b) EX req in flight marks it as stale.
//  Each stale req increments cancel_cnt (1 bit).
//  data_ok with cancel_cnt!=0 decrements the counter and is discarded; it never completes an instruction.
//  Simultaneous flush and data_ok for the current req: the response is consumed and cancel_cnt is unchanged.
//  Reset mid-load: counter and flags clear asynchronously; the SRAM side is reset with the core.
//  ms_ex_flag = ms_valid & (any exception bit | ertn | refetch).
// STRUCTURE
//  cpuhead.h: ECODE_*, the EX2MS/MS2WS bus widths (86, 10), and LD_OP one-hot bit indices.
//  Sub-module: mem_load_ext (comb: rdata, addr[1:0], ld_op -> 32-bit wdata).
// TESTING
//  ld.w, data_ok the next cycle, ws_allowin=1 -> ms_to_ws_valid 1 cycle after accept, wdata=rdata.
//  ld.b addr[1:0]=3, rdata=0x80AABBCC -> wdata=0xFFFFFF80; ld.bu -> 0x00000080; ld.hu addr=2 -> 0x000080AA.
//  data_ok 3 cycles late -> ms_allowin=0 and ms_fwd_blk=1 until data_ok; EX bundle held stable.
//  data_ok while ws_allowin=0 for 2 cycles -> wdata taken from buffer, no loss, single handoff.
//  wb_ex with load pending -> ms_valid 0; next late data_ok dropped; following ld gets its own data.
//  Accepted instr with ale=1 -> passes to WB without data_ok; ms_ex_flag=1; no rf bypass.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths, bundle bit positions and load-op encoding for the MEM stage.
package mem_stage_pkg;
    localparam int EX2MS_W = 86;
    localparam int TLB_W   = 10;

    // one-hot es_ld_op = {ld.w, ld.h, ld.hu, ld.b, ld.bu}
    localparam int LD_W  = 4;
    localparam int LD_H  = 3;
    localparam int LD_HU = 2;
    localparam int LD_B  = 1;
    localparam int LD_BU = 0;

    // low bits of the EX->MEM exception bundle
    localparam int EX_ALE  = 0;
    localparam int EX_INT  = 5;
    localparam int EX_ERTN = 6;

    localparam int TLB_REFETCH = 9;

    function automatic logic has_exc(input logic [EX_INT:EX_ALE] bits);
        return |bits;
    endfunction
endpackage

// File: rtl/mem_load_ext.sv
// Selects the addressed byte/half of the load word and sign- or zero-extends it.
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [4:0]  ld_op,
    output logic [31:0] wdata
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        wdata    = rdata;
        if (ld_op[LD_W])       wdata = rdata;
        else if (ld_op[LD_B])  wdata = {{24{byte_sel[7]}}, byte_sel};
        else if (ld_op[LD_BU]) wdata = {24'b0, byte_sel};
        else if (ld_op[LD_H])  wdata = {{16{half_sel[15]}}, half_sel};
        else if (ld_op[LD_HU]) wdata = {16'b0, half_sel};
    end
endmodule

// File: rtl/mem_stage.sv
// MEM stage: waits for data-SRAM responses, extends load data, and drops stale responses after WB flushes.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               es_to_ms_valid,
    output logic               ms_allowin,
    input  logic [31:0]        es_pc,
    input  logic [31:0]        es_result,
    input  logic [4:0]         es_rf_waddr,
    input  logic               es_rf_we,
    input  logic               es_mem_req,
    input  logic [4:0]         es_ld_op,
    input  logic               es_csr_re,
    input  logic [EX2MS_W-1:0] es_ex_zip,
    input  logic [TLB_W-1:0]   es2ms_tlb_zip,
    input  logic               data_sram_data_ok,
    input  logic [31:0]        data_sram_rdata,
    input  logic               ws_allowin,
    output logic               ms_to_ws_valid,
    output logic [31:0]        ms_pc,
    output logic [31:0]        ms_result,
    output logic [31:0]        ms_rf_wdata,
    output logic [4:0]         ms_rf_waddr,
    output logic               ms_rf_we,
    output logic               ms_csr_re,
    output logic [EX2MS_W-1:0] ms_ex_zip,
    output logic [TLB_W-1:0]   ms2ws_tlb_zip,
    output logic               ms_fwd_we,
    output logic               ms_fwd_blk,
    output logic               ms_ex_flag,
    input  logic               wb_ex,
    input  logic               ertn_flush,
    input  logic               wb_refetch_flush
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic             ms_valid;
    logic             mem_req_r;
    logic             data_ok_seen;
    logic [4:0]       ld_op_r;
    logic [31:0]      rdata_buf;
    logic [CNT_W-1:0] cancel_cnt;
    logic [CNT_W:0]   cnt_nxt;

    logic        flush, accept, ms_has_ex, is_ld, ms_ready_go;
    logic        ok_fresh, ms_wait, ok_cur, stale_ms, stale_es;
    logic [31:0] ld_wdata;

    assign flush     = wb_ex | ertn_flush | wb_refetch_flush;
    assign ms_has_ex = has_exc(ms_ex_zip[EX_INT:EX_ALE]);
    assign is_ld     = |ld_op_r;

    // a response is only ours when no cancelled request is still draining
    assign ok_fresh = data_sram_data_ok & (cancel_cnt == '0);
    assign ms_wait  = ms_valid & mem_req_r & ~data_ok_seen & ~ms_has_ex;
    assign ok_cur   = ok_fresh & ms_wait;

    assign ms_ready_go    = ms_has_ex | ~mem_req_r | data_ok_seen | ok_fresh;
    assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go & ~flush;
    assign accept         = es_to_ms_valid & ms_allowin & ~flush;

    // a fresh response with nothing waiting in MEM belongs to the EX request
    assign stale_ms = ms_wait & ~ok_fresh;
    assign stale_es = es_to_ms_valid & es_mem_req & ~(ok_fresh & ~ms_wait);

    always_comb begin
        cnt_nxt = {1'b0, cancel_cnt};
        if (flush & stale_ms) cnt_nxt = cnt_nxt + (CNT_W+1)'(1);
        if (flush & stale_es) cnt_nxt = cnt_nxt + (CNT_W+1)'(1);
        if (data_sram_data_ok && cancel_cnt != '0) cnt_nxt = cnt_nxt - (CNT_W+1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid      <= 1'b0;
            mem_req_r     <= 1'b0;
            data_ok_seen  <= 1'b0;
            ld_op_r       <= '0;
            rdata_buf     <= '0;
            cancel_cnt    <= '0;
            ms_pc         <= '0;
            ms_result     <= '0;
            ms_rf_waddr   <= '0;
            ms_rf_we      <= 1'b0;
            ms_csr_re     <= 1'b0;
            ms_ex_zip     <= '0;
            ms2ws_tlb_zip <= '0;
        end else begin
            cancel_cnt <= cnt_nxt[CNT_W-1:0];
            if (flush)           ms_valid <= 1'b0;
            else if (ms_allowin) ms_valid <= es_to_ms_valid;
            if (accept) begin
                ms_pc         <= es_pc;
                ms_result     <= es_result;
                ms_rf_waddr   <= es_rf_waddr;
                ms_rf_we      <= es_rf_we;
                mem_req_r     <= es_mem_req;
                ld_op_r       <= es_ld_op;
                ms_csr_re     <= es_csr_re;
                ms_ex_zip     <= es_ex_zip;
                ms2ws_tlb_zip <= es2ms_tlb_zip;
                data_ok_seen  <= 1'b0;
            end else if (ok_cur) begin
                data_ok_seen <= 1'b1;
                rdata_buf    <= data_sram_rdata;
            end
        end
    end

    mem_load_ext u_load_ext (
        .rdata (data_ok_seen ? rdata_buf : data_sram_rdata),
        .addr  (ms_result[1:0]),
        .ld_op (ld_op_r),
        .wdata (ld_wdata)
    );

    assign ms_rf_wdata = (is_ld & ~ms_has_ex) ? ld_wdata : ms_result;
    assign ms_fwd_we   = ms_valid & ms_rf_we & ~ms_has_ex;
    assign ms_fwd_blk  = ms_valid & (ms_csr_re | (is_ld & ~ms_ready_go));
    assign ms_ex_flag  = ms_valid & (ms_has_ex | ms_ex_zip[EX_ERTN] | ms2ws_tlb_zip[TLB_REFETCH]);
endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized load traffic for mem_stage, checked against an arithmetic load model.
module tb_mem_stage;
    logic        clk, reset;
    logic        es_to_ms_valid, ms_allowin;
    logic [31:0] es_pc, es_result;
    logic [4:0]  es_rf_waddr;
    logic        es_rf_we, es_mem_req;
    logic [4:0]  es_ld_op;
    logic        es_csr_re;
    logic [85:0] es_ex_zip;
    logic [9:0]  es2ms_tlb_zip;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin, ms_to_ws_valid;
    logic [31:0] ms_pc, ms_result, ms_rf_wdata;
    logic [4:0]  ms_rf_waddr;
    logic        ms_rf_we, ms_csr_re;
    logic [85:0] ms_ex_zip;
    logic [9:0]  ms2ws_tlb_zip;
    logic        ms_fwd_we, ms_fwd_blk, ms_ex_flag;
    logic        wb_ex, ertn_flush, wb_refetch_flush;

    int passed = 0, fails = 0, total = 0;

    localparam logic [4:0] OP_W = 5'b10000, OP_H = 5'b01000, OP_HU = 5'b00100,
                           OP_B = 5'b00010, OP_BU = 5'b00001;

    mem_stage dut (
        .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_pc(es_pc), .es_result(es_result), .es_rf_waddr(es_rf_waddr), .es_rf_we(es_rf_we),
        .es_mem_req(es_mem_req), .es_ld_op(es_ld_op), .es_csr_re(es_csr_re), .es_ex_zip(es_ex_zip),
        .es2ms_tlb_zip(es2ms_tlb_zip), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
        .ms_pc(ms_pc), .ms_result(ms_result), .ms_rf_wdata(ms_rf_wdata), .ms_rf_waddr(ms_rf_waddr),
        .ms_rf_we(ms_rf_we), .ms_csr_re(ms_csr_re), .ms_ex_zip(ms_ex_zip),
        .ms2ws_tlb_zip(ms2ws_tlb_zip), .ms_fwd_we(ms_fwd_we), .ms_fwd_blk(ms_fwd_blk),
        .ms_ex_flag(ms_ex_flag), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
        .wb_refetch_flush(wb_refetch_flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [85:0] obs, input logic [85:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        es_to_ms_valid = 0; es_mem_req = 0; es_ld_op = 0; es_csr_re = 0; es_rf_we = 0;
        es_ex_zip = '0; es2ms_tlb_zip = '0; data_sram_data_ok = 0; ws_allowin = 1;
        wb_ex = 0; ertn_flush = 0; wb_refetch_flush = 0;
    endtask

    task automatic drive_es(input logic [4:0] op, input logic [31:0] res, input logic [31:0] pc,
                            input logic req);
        es_to_ms_valid = 1; es_ld_op = op; es_result = res; es_pc = pc; es_mem_req = req;
        es_rf_we = 1; es_rf_waddr = 5'($urandom_range(1, 31));
    endtask

    // Reference: pick the addressed byte/half arithmetically and extend by value
    function automatic logic [31:0] ref_ld(input logic [4:0] op, input int addr, input logic [31:0] rd);
        logic [31:0] v;
        v = rd;
        case (op)
            OP_B:  begin v = (rd >> (addr * 8)) % 256;   if (v >= 128)   v = v + 32'hFFFFFF00; end
            OP_BU: v = (rd >> (addr * 8)) % 256;
            OP_H:  begin v = (rd >> (addr * 8)) % 65536; if (v >= 32768) v = v + 32'hFFFF0000; end
            OP_HU: v = (rd >> (addr * 8)) % 65536;
            default: v = rd;
        endcase
        return v;
    endfunction

    // One load through MEM: response lat cycles after accept, WB stalls for `stall` cycles
    task automatic run_load(input logic [4:0] op, input int addr, input logic [31:0] rd,
                            input int lat, input int stall);
        logic [31:0] exp, pc, res;
        int hand;
        exp = ref_ld(op, addr, rd);
        pc  = $urandom;
        res = {$urandom_range(0, 32'h3FFFFFFF), 2'(addr)};
        hand = 0;
        idle();
        drive_es(op, res, pc, 1);
        settle();
        chk("accept_allowin", 86'(ms_allowin), 86'(1));
        step();
        idle();
        for (int i = 1; i < lat; i++) begin
            settle();
            chk("wait_allowin", 86'(ms_allowin), 86'(0));
            chk("wait_fwd_blk", 86'(ms_fwd_blk), 86'(1));
            chk("wait_valid", 86'(ms_to_ws_valid), 86'(0));
            chk("hold_pc", 86'(ms_pc), 86'(pc));
            step();
        end
        data_sram_data_ok = 1; data_sram_rdata = rd; ws_allowin = (stall == 0);
        settle();
        chk("resp_valid", 86'(ms_to_ws_valid), 86'(1));
        chk("resp_wdata", 86'(ms_rf_wdata), 86'(exp));
        if (ms_to_ws_valid && ws_allowin) hand++;
        step();
        data_sram_data_ok = 0; data_sram_rdata = $urandom;
        for (int i = 0; i < stall; i++) begin
            ws_allowin = (i == stall - 1);
            settle();
            chk("buf_valid", 86'(ms_to_ws_valid), 86'(1));
            chk("buf_wdata", 86'(ms_rf_wdata), 86'(exp));
            if (ms_to_ws_valid && ws_allowin) hand++;
            step();
        end
        ws_allowin = 1;
        settle();
        chk("after_valid", 86'(ms_to_ws_valid), 86'(0));
        chk("after_allowin", 86'(ms_allowin), 86'(1));
        chk("handoffs", 86'(hand), 86'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [85:0] zip;
        logic [4:0]  op;
        int          a;
        clk = 0; reset = 1; es_pc = 0; es_result = 0; es_rf_waddr = 0; data_sram_rdata = 0;
        idle();
        #12;
        chk("rst_allowin", 86'(ms_allowin), 86'(1));
        chk("rst_valid", 86'(ms_to_ws_valid), 86'(0));
        chk("rst_pc", 86'(ms_pc), 86'(0));
        chk("rst_ex_zip", ms_ex_zip, 86'(0));
        chk("rst_flags", 86'({ms_fwd_we, ms_fwd_blk, ms_ex_flag, ms_rf_we}), 86'(0));
        @(negedge clk); reset = 0;
        step();

        // zero-latency ld.w and the extension cases
        run_load(OP_W, 0, 32'h1234ABCD, 1, 0);
        run_load(OP_B, 3, 32'h80AABBCC, 1, 0);
        run_load(OP_BU, 3, 32'h80AABBCC, 1, 0);
        run_load(OP_HU, 2, 32'h80AABBCC, 1, 0);
        run_load(OP_H, 2, 32'h80AABBCC, 1, 0);
        // late response and WB back-pressure
        run_load(OP_W, 0, 32'hCAFEF00D, 4, 0);
        run_load(OP_B, 1, 32'h0000F100, 1, 2);

        // ALU result pass-through with bypass
        idle(); drive_es(5'b0, 32'h12345678, 32'h1C000000, 0); es2ms_tlb_zip = 10'h155;
        step(); idle(); settle();
        chk("alu_valid", 86'(ms_to_ws_valid), 86'(1));
        chk("alu_wdata", 86'(ms_rf_wdata), 86'(32'h12345678));
        chk("alu_fwd_we", 86'(ms_fwd_we), 86'(1));
        chk("alu_fwd_blk", 86'(ms_fwd_blk), 86'(0));
        chk("alu_tlb_zip", 86'(ms2ws_tlb_zip), 86'(10'h155));
        step();

        // CSR read blocks bypass while held
        idle(); drive_es(5'b0, 32'h0, 32'h1C000004, 0); es_csr_re = 1;
        step(); idle(); ws_allowin = 0; settle();
        chk("csr_fwd_blk", 86'(ms_fwd_blk), 86'(1));
        chk("csr_allowin", 86'(ms_allowin), 86'(0));
        step(); ws_allowin = 1; step();

        // misaligned ld.w with ale set: no SRAM wait, no bypass
        idle(); zip = 86'(1) | (86'($urandom) << 7); drive_es(OP_W, 32'h00000102, 32'h1C000008, 0);
        es_ex_zip = zip;
        step(); idle(); settle();
        chk("ale_valid", 86'(ms_to_ws_valid), 86'(1));
        chk("ale_ex_flag", 86'(ms_ex_flag), 86'(1));
        chk("ale_fwd_we", 86'(ms_fwd_we), 86'(0));
        chk("ale_zip", ms_ex_zip, zip);
        chk("ale_result", 86'(ms_result), 86'(32'h00000102));
        step(); settle();
        chk("ale_gone", 86'(ms_ex_flag), 86'(0));

        // flush with MEM waiting; the late stale response must not complete the next load
        idle(); drive_es(OP_W, 32'h40, 32'h1C000010, 1); step();
        idle(); settle(); chk("fl_wait_blk", 86'(ms_fwd_blk), 86'(1)); step();
        wb_ex = 1; settle(); chk("fl_valid", 86'(ms_to_ws_valid), 86'(0)); step();
        idle(); drive_es(OP_W, 32'h44, 32'h1C000014, 1); settle();
        chk("fl_allowin", 86'(ms_allowin), 86'(1));
        step();
        idle(); data_sram_data_ok = 1; data_sram_rdata = 32'hDEADBEEF; settle();
        chk("stale_valid", 86'(ms_to_ws_valid), 86'(0));
        chk("stale_allowin", 86'(ms_allowin), 86'(0));
        step();
        data_sram_rdata = 32'h0BADC0DE; settle();
        chk("own_valid", 86'(ms_to_ws_valid), 86'(1));
        chk("own_wdata", 86'(ms_rf_wdata), 86'(32'h0BADC0DE));
        chk("own_pc", 86'(ms_pc), 86'(32'h1C000014));
        step();
        idle(); settle(); chk("own_done", 86'(ms_to_ws_valid), 86'(0));

        // flush while the EX request is in flight
        idle(); drive_es(OP_W, 32'h48, 32'h1C000018, 1); ertn_flush = 1; step();
        idle(); data_sram_data_ok = 1; data_sram_rdata = 32'hDEADBEEF; settle();
        chk("es_stale_valid", 86'(ms_to_ws_valid), 86'(0));
        chk("es_stale_allowin", 86'(ms_allowin), 86'(1));
        step();
        run_load(OP_W, 0, 32'h5A5A1234, 1, 0);

        // flush coincident with the current response: consumed, nothing left to drain
        idle(); drive_es(OP_W, 32'h4C, 32'h1C00001C, 1); step();
        idle(); data_sram_data_ok = 1; data_sram_rdata = 32'h11111111; wb_refetch_flush = 1; settle();
        chk("coinc_valid", 86'(ms_to_ws_valid), 86'(0));
        step();
        run_load(OP_B, 3, 32'h80AABBCC, 1, 0);

        // randomized loads
        for (int n = 0; n < 30; n++) begin
            op = 5'(1 << $urandom_range(0, 4));
            if (op == OP_W) a = 0;
            else if (op == OP_H || op == OP_HU) a = 2 * $urandom_range(0, 1);
            else a = $urandom_range(0, 3);
            run_load(op, a, $urandom, $urandom_range(1, 4), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
